// File: rtl/finv_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : finv_arb_pkg
// Purpose  : Shared types and round-robin pick function for finv/fsqrt sharing.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package finv_arb_pkg;

    localparam int c_max_nreq = 8;
    localparam int c_tagw     = 3;

    typedef logic [31:0] fp32_t;

    typedef struct packed {
        logic              vld;
        logic [c_tagw-1:0] tag;
    } tag_ent_t;

    // Search from ptr upward, wrapping at n; first set request wins.
    function automatic logic [c_max_nreq-1:0] rr_pick(
        input logic [c_max_nreq-1:0] req,
        input logic [c_tagw-1:0]     ptr,
        input int                    n
    );
        logic [c_max_nreq-1:0] grant;
        logic                  found;
        int                    idx;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < c_max_nreq; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && !found && req[idx[c_tagw-1:0]]) begin
                grant[idx[c_tagw-1:0]] = 1'b1;
                found                  = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : rr_arbiter
// Purpose  : Combinational round-robin grant with a registered rotating pointer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
    import finv_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   i_req,
    output logic [NREQ-1:0]   o_grant,
    output logic [c_tagw-1:0] o_grant_idx
);

    localparam logic [c_tagw-1:0] c_last = c_tagw'(NREQ - 1);

    logic [c_tagw-1:0]     r_ptr;
    logic [c_max_nreq-1:0] w_req_ext;
    logic [c_max_nreq-1:0] w_pick;

    always_comb begin
        w_req_ext   = c_max_nreq'(i_req);
        w_pick      = rr_pick(w_req_ext, r_ptr, NREQ);
        o_grant     = rst ? '0 : NREQ'(w_pick);
        o_grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (o_grant[i]) begin
                o_grant_idx = c_tagw'(i);
            end
        end
    end

    // Any grant is an accepted handshake, since grants only go to valid requesters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (|o_grant) begin
            r_ptr <= (o_grant_idx == c_last) ? '0 : o_grant_idx + c_tagw'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/finv_share_arb.sv
//------------------------------------------------------------------------------
// Module   : finv_share_arb
// Purpose  : Shares one fixed-latency finv pipe among NREQ requesters with tagged returns.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module finv_share_arb
    import finv_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [NREQ*32-1:0] req_x,
    output logic [NREQ-1:0]  req_ready,
    output logic [NREQ-1:0]  resp_valid,
    output fp32_t            resp_y,
    output fp32_t            finv_x,
    input  fp32_t            finv_y,
    output logic             busy
);

    logic [NREQ-1:0]   w_grant;
    logic [c_tagw-1:0] w_grant_idx;
    tag_ent_t          r_pipe [LATENCY];
    tag_ent_t          w_last;
    logic [NREQ-1:0]   w_resp_hot;
    logic              w_pipe_busy;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .i_req       (req_valid),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    assign req_ready = w_grant;

    always_comb begin
        finv_x = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                finv_x = req_x[32*i +: 32];
            end
        end
    end

    assign w_last = r_pipe[LATENCY-1];

    always_comb begin
        w_resp_hot = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_resp_hot[i] = w_last.vld && (w_last.tag == c_tagw'(i));
        end
    end

    // The tag pipe runs in lockstep with the finv, so its last stage names the owner of finv_y.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < LATENCY; s++) begin
                r_pipe[s] <= '0;
            end
            resp_valid <= '0;
            resp_y     <= '0;
        end else begin
            r_pipe[0] <= {|w_grant, w_grant_idx};
            for (int s = 1; s < LATENCY; s++) begin
                r_pipe[s] <= r_pipe[s-1];
            end
            resp_valid <= w_resp_hot;
            if (w_last.vld) begin
                resp_y <= finv_y;
            end
        end
    end

    always_comb begin
        w_pipe_busy = 1'b0;
        for (int s = 0; s < LATENCY; s++) begin
            w_pipe_busy = w_pipe_busy | r_pipe[s].vld;
        end
    end

    assign busy = w_pipe_busy | (|resp_valid);

endmodule

`default_nettype wire

// File: tb/tb_finv_share_arb.sv
//------------------------------------------------------------------------------
// Module   : tb_finv_share_arb
// Purpose  : Self-checking bench for finv_share_arb with a behavioural 2-edge finv.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_finv_share_arb;

    localparam int NREQ    = 4;
    localparam int LATENCY = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [127:0] req_x = '0;
    logic [3:0]   req_ready;
    logic [3:0]   resp_valid;
    logic [31:0]  resp_y;
    logic [31:0]  finv_x;
    logic [31:0]  finv_y;
    logic         busy;
    logic [31:0]  f1, f2;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          tag;
        logic [31:0] y;
        int          due;
    } exp_t;

    exp_t        mdl_q[$];
    int          mdl_ptr;
    logic [31:0] mdl_y;

    always #5 clk = ~clk;

    finv_share_arb #(
        .NREQ    (NREQ),
        .LATENCY (LATENCY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_y     (resp_y),
        .finv_x     (finv_x),
        .finv_y     (finv_y),
        .busy       (busy)
    );

    // Exact reciprocal for signed powers of two; anything else maps to a quiet NaN.
    function automatic logic [31:0] recip(input logic [31:0] x);
        logic [7:0] e;
        e = x[30:23];
        if (x[22:0] == 23'h0 && e >= 8'd1 && e <= 8'd253)
            return {x[31], 8'd254 - e, 23'h0};
        return 32'h7FC0_0000;
    endfunction

    function automatic logic [31:0] rand_pow2();
        logic       s;
        logic [7:0] e;
        s = 1'($urandom_range(0, 1));
        e = 8'($urandom_range(1, 253));
        return {s, e, 23'h0};
    endfunction

    always @(posedge clk) begin
        f1 <= recip(finv_x);
        f2 <= f1;
    end
    assign finv_y = f2;

    // Reference arbiter: first valid requester at or after the pointer, modulo NREQ.
    function automatic int model_pick(input logic [3:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(mdl_ptr + k) % NREQ]) return (mdl_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'hF;
        req_x = {32'h3F00_0000, 32'h4080_0000, 32'h4000_0000, 32'h3F80_0000};
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            #4;
            n_cmp++;
            if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready c%0d: got %b want 0000", c, req_ready); end
            n_cmp++;
            if (resp_valid !== 4'b0000) begin n_err++; $display("FAIL reset_resp_valid c%0d: got %b want 0000", c, resp_valid); end
            n_cmp++;
            if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy c%0d: got %b want 0", c, busy); end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #4;
        n_cmp++;
        if (req_ready !== 4'b0001) begin n_err++; $display("FAIL reset_first_grant: got %b want 0001", req_ready); end
        n_cmp++;
        if (finv_x !== 32'h3F80_0000) begin n_err++; $display("FAIL reset_first_x: got %h want 3f800000", finv_x); end
        req_valid = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_op();
        logic [3:0] exp_rv;
        req_valid = 4'b0010;
        req_x[63:32] = 32'h4000_0000;
        #4;
        n_cmp++;
        if (req_ready !== 4'b0010) begin n_err++; $display("FAIL single_grant: got %b want 0010", req_ready); end
        n_cmp++;
        if (finv_x !== 32'h4000_0000) begin n_err++; $display("FAIL single_x: got %h want 40000000", finv_x); end
        @(posedge clk); #1;
        req_valid = '0;
        for (int k = 1; k <= 4; k++) begin
            #4;
            exp_rv = (k == 3) ? 4'b0010 : 4'b0000;
            n_cmp++;
            if (req_ready !== 4'b0000) begin n_err++; $display("FAIL single_ready k%0d: got %b want 0000", k, req_ready); end
            n_cmp++;
            if (resp_valid !== exp_rv) begin n_err++; $display("FAIL single_resp_valid k%0d: got %b want %b", k, resp_valid, exp_rv); end
            n_cmp++;
            if (busy !== (k <= 3)) begin n_err++; $display("FAIL single_busy k%0d: got %b want %b", k, busy, k <= 3); end
            if (k == 3) begin
                n_cmp++;
                if (resp_y !== 32'h3F00_0000) begin n_err++; $display("FAIL single_resp_y: got %h want 3f000000", resp_y); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] xs [4];
        logic [31:0] ys [4];
        logic [3:0]  exp_g, exp_rv;
        xs = '{32'h3F80_0000, 32'h4000_0000, 32'h4080_0000, 32'h3F00_0000};
        ys = '{32'h3F80_0000, 32'h3F00_0000, 32'h3E80_0000, 32'h4000_0000};
        do_reset();
        req_x = {xs[3], xs[2], xs[1], xs[0]};
        for (int k = 0; k < 11; k++) begin
            req_valid = (k < 8) ? 4'hF : 4'h0;
            #4;
            exp_g = (k < 8) ? 4'(1 << (k % 4)) : 4'h0;
            n_cmp++;
            if (req_ready !== exp_g) begin n_err++; $display("FAIL rr_grant k%0d: got %b want %b", k, req_ready, exp_g); end
            if (k < 8) begin
                n_cmp++;
                if (finv_x !== xs[k % 4]) begin n_err++; $display("FAIL rr_x k%0d: got %h want %h", k, finv_x, xs[k % 4]); end
            end
            exp_rv = (k >= 3) ? 4'(1 << ((k - 3) % 4)) : 4'h0;
            n_cmp++;
            if (resp_valid !== exp_rv) begin n_err++; $display("FAIL rr_resp_valid k%0d: got %b want %b", k, resp_valid, exp_rv); end
            if (k >= 3) begin
                n_cmp++;
                if (resp_y !== ys[(k - 3) % 4]) begin n_err++; $display("FAIL rr_resp_y k%0d: got %h want %h", k, resp_y, ys[(k - 3) % 4]); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fairness_skip();
        logic [3:0]  vals [3];
        logic [3:0]  gnts [3];
        logic [31:0] lx [4];
        int          owner [3];
        logic [3:0]  exp_g;
        vals  = '{4'b0010, 4'b1001, 4'b0001};
        gnts  = '{4'b0010, 4'b1000, 4'b0001};
        owner = '{1, 3, 0};
        for (int i = 0; i < 4; i++) lx[i] = rand_pow2();
        req_x = {lx[3], lx[2], lx[1], lx[0]};
        for (int k = 0; k < 6; k++) begin
            req_valid = (k < 3) ? vals[k] : 4'h0;
            #4;
            exp_g = (k < 3) ? gnts[k] : 4'h0;
            n_cmp++;
            if (req_ready !== exp_g) begin n_err++; $display("FAIL skip_grant k%0d: got %b want %b", k, req_ready, exp_g); end
            if (k >= 3) begin
                n_cmp++;
                if (resp_valid !== gnts[k - 3]) begin n_err++; $display("FAIL skip_resp_valid k%0d: got %b want %b", k, resp_valid, gnts[k - 3]); end
                n_cmp++;
                if (resp_y !== recip(lx[owner[k - 3]])) begin n_err++; $display("FAIL skip_resp_y k%0d: got %h want %h", k, resp_y, recip(lx[owner[k - 3]])); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_midflight();
        req_valid = 4'b0100;
        req_x[95:64] = 32'h4100_0000;
        #4;
        n_cmp++;
        if (req_ready !== 4'b0100) begin n_err++; $display("FAIL midrst_grant: got %b want 0100", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #4;
            n_cmp++;
            if (resp_valid !== 4'b0000) begin n_err++; $display("FAIL midrst_resp_valid k%0d: got %b want 0000", k, resp_valid); end
            n_cmp++;
            if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy k%0d: got %b want 0", k, busy); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_withdrawal();
        logic [3:0] exp_rv;
        req_x[63:32]  = 32'h3E00_0000;
        req_x[127:96] = 32'h4200_0000;
        req_valid = 4'b1010;
        #4;
        n_cmp++;
        if (req_ready !== 4'b0010) begin n_err++; $display("FAIL wd_grant_before: got %b want 0010", req_ready); end
        #1;
        req_valid = 4'b1000;
        #2;
        n_cmp++;
        if (req_ready !== 4'b1000) begin n_err++; $display("FAIL wd_grant_after: got %b want 1000", req_ready); end
        n_cmp++;
        if (finv_x !== 32'h4200_0000) begin n_err++; $display("FAIL wd_x: got %h want 42000000", finv_x); end
        @(posedge clk); #1;
        req_valid = '0;
        for (int k = 1; k <= 4; k++) begin
            #4;
            exp_rv = (k == 3) ? 4'b1000 : 4'b0000;
            n_cmp++;
            if (resp_valid !== exp_rv) begin n_err++; $display("FAIL wd_resp_valid k%0d: got %b want %b", k, resp_valid, exp_rv); end
            if (k == 3) begin
                n_cmp++;
                if (resp_y !== 32'h3D00_0000) begin n_err++; $display("FAIL wd_resp_y: got %h want 3d000000", resp_y); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random(input int ncyc);
        logic [3:0]  exp_g, exp_rv;
        logic [31:0] exp_x;
        int          gi;
        do_reset();
        mdl_q.delete();
        mdl_ptr = 0;
        mdl_y   = '0;
        for (int cyc = 0; cyc < ncyc + 6; cyc++) begin
            req_valid = (cyc < ncyc) ? 4'($urandom_range(0, 15)) : 4'h0;
            for (int i = 0; i < 4; i++) req_x[32*i +: 32] = rand_pow2();
            #4;
            gi    = model_pick(req_valid);
            exp_g = (gi < 0) ? 4'h0 : 4'(1 << gi);
            exp_x = (gi < 0) ? 32'h0 : req_x[32*gi +: 32];
            exp_rv = 4'h0;
            if (mdl_q.size() > 0 && mdl_q[0].due == cyc) begin
                exp_rv = 4'(1 << mdl_q[0].tag);
                mdl_y  = mdl_q[0].y;
            end
            n_cmp++;
            if (req_ready !== exp_g) begin n_err++; $display("FAIL rnd_grant c%0d: got %b want %b", cyc, req_ready, exp_g); end
            n_cmp++;
            if (finv_x !== exp_x) begin n_err++; $display("FAIL rnd_x c%0d: got %h want %h", cyc, finv_x, exp_x); end
            n_cmp++;
            if (resp_valid !== exp_rv) begin n_err++; $display("FAIL rnd_resp_valid c%0d: got %b want %b", cyc, resp_valid, exp_rv); end
            n_cmp++;
            if (resp_y !== mdl_y) begin n_err++; $display("FAIL rnd_resp_y c%0d: got %h want %h", cyc, resp_y, mdl_y); end
            n_cmp++;
            if (busy !== (mdl_q.size() > 0)) begin n_err++; $display("FAIL rnd_busy c%0d: got %b want %b", cyc, busy, mdl_q.size() > 0); end
            if (mdl_q.size() > 0 && mdl_q[0].due == cyc) void'(mdl_q.pop_front());
            if (gi >= 0) begin
                mdl_q.push_back('{tag: gi, y: recip(exp_x), due: cyc + LATENCY + 1});
                mdl_ptr = (gi + 1) % NREQ;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_round_robin();
        test_fairness_skip();
        test_reset_midflight();
        test_withdrawal();
        test_random(300);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
